// File: rtl/axi_mem_pkg.sv
// Shared constants and FSM state types for the AXI bring-up memory.
// Optional build macro: AXI_MEM_DECERR_EN (see axi_mem_slave.sv).
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

endpackage

// File: rtl/axi_mem_bank.sv
// Word-wide RAM: one byte-enable write port and one synchronous read port.
// The read register only updates when i_re is high, so it doubles as the
// holding register for a stalled read beat. A read and a write to the same
// word on one edge return the pre-write contents.
module axi_mem_bank #(
    parameter int DATA_WIDTH = 128,
    parameter int MEM_WORDS  = 1024,
    parameter int IW         = 10
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [IW-1:0]           i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_re,
    input  logic [IW-1:0]           i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] r_dout;

    // Byte-enabled write of one word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read, held while i_re is low.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_dout <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_dout;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI responder memory behind the core's AXI master bridge. All bursts are
// INCR of full-width beats; the word index is addr[IW+3:4] and wraps.
// Read and write channels are independent FSMs sharing one axi_mem_bank.
// Optional build macro: AXI_MEM_DECERR_EN -- start addresses beyond the RAM
// answer DECERR instead of aliasing onto it.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a source holds valid and its payload stable
// until that edge, and ready never depends combinationally on valid.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output rd_state_t               o_dbg_rd_state,
    output wr_state_t               o_dbg_wr_state
);

    localparam int IW = $clog2(MEM_WORDS);

    // Low byte-offset bits are ignored; upper bits only matter for DECERR.
    logic w_unused;
    assign w_unused = ^{araddr, awaddr};

    logic w_ar_decerr;
    logic w_aw_decerr;
`ifdef AXI_MEM_DECERR_EN
    assign w_ar_decerr = (araddr >> (IW + 4)) != '0;
    assign w_aw_decerr = (awaddr >> (IW + 4)) != '0;
`else
    assign w_ar_decerr = 1'b0;
    assign w_aw_decerr = 1'b0;
`endif

    // ---------------- read channel ----------------
    rd_state_t             r_rd_state, w_rd_next;
    logic                  r_arready, r_rvalid, r_rlast, r_rdecerr;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [IW-1:0]         r_ridx;
    logic [7:0]            r_rrem;
    logic                  w_ar_hs, w_r_hs, w_re;
    logic [IW-1:0]         w_raddr;
    logic [DATA_WIDTH-1:0] w_bank_rdata;

    assign w_ar_hs = arvalid & r_arready;
    assign w_r_hs  = r_rvalid & rready;

    // Read next-state and RAM read-port control.
    always_comb begin
        w_rd_next = r_rd_state;
        w_re      = 1'b0;
        w_raddr   = r_ridx;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_next = R_DATA;
                    w_re      = 1'b1;
                    w_raddr   = araddr[IW+3:4];
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    if (r_rlast) begin
                        w_rd_next = R_IDLE;
                    end else begin
                        w_re    = 1'b1;
                        w_raddr = r_ridx + IW'(1);
                    end
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Read state register, registered channel outputs and burst tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdecerr  <= 1'b0;
            r_rid      <= '0;
            r_ridx     <= '0;
            r_rrem     <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= (w_rd_next == R_IDLE);
            r_rvalid   <= (w_rd_next == R_DATA);
            if (r_rd_state == R_IDLE && w_ar_hs) begin
                r_rid     <= arid;
                r_ridx    <= araddr[IW+3:4];
                r_rrem    <= arlen;
                r_rlast   <= (arlen == 8'd0);
                r_rdecerr <= w_ar_decerr;
            end else if (r_rd_state == R_DATA && w_r_hs) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_ridx  <= r_ridx + IW'(1);
                    r_rrem  <= r_rrem - 8'd1;
                    r_rlast <= (r_rrem == 8'd1);
                end
            end
        end
    end

    assign arready        = r_arready;
    assign rvalid         = r_rvalid;
    assign rlast          = r_rlast;
    assign rid            = r_rid;
    assign rdata          = (r_rvalid && !r_rdecerr) ? w_bank_rdata : '0;
    assign rresp          = (r_rvalid && r_rdecerr) ? RESP_DECERR : RESP_OKAY;
    assign o_dbg_rd_state = r_rd_state;

    // ---------------- write channel ----------------
    wr_state_t           r_wr_state, w_wr_next;
    logic                r_awready, r_wready, r_bvalid, r_wdecerr;
    logic [ID_WIDTH-1:0] r_awid, r_bid;
    logic [IW-1:0]       r_widx;
    logic [7:0]          r_awlen;
    logic [8:0]          r_wcnt;
    logic [1:0]          r_bresp;
    logic                w_aw_hs, w_w_hs, w_b_hs, w_we;

    assign w_aw_hs = awvalid & r_awready;
    assign w_w_hs  = wvalid & r_wready;
    assign w_b_hs  = r_bvalid & bready;
    // No RAM write while reset is asserted, even if a beat is presented.
    assign w_we    = w_w_hs & ~r_wdecerr & ~reset;

    // Write next-state.
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_next = W_DATA;
            W_DATA:  if (w_w_hs && wlast) w_wr_next = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Write state register, registered channel outputs and beat accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_wdecerr  <= 1'b0;
            r_awid     <= '0;
            r_bid      <= '0;
            r_widx     <= '0;
            r_awlen    <= '0;
            r_wcnt     <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= (w_wr_next == W_IDLE);
            r_wready   <= (w_wr_next == W_DATA);
            r_bvalid   <= (w_wr_next == W_RESP);
            if (w_aw_hs) begin
                r_awid    <= awid;
                r_widx    <= awaddr[IW+3:4];
                r_awlen   <= awlen;
                r_wcnt    <= '0;
                r_wdecerr <= w_aw_decerr;
            end
            if (w_w_hs) begin
                r_widx <= r_widx + IW'(1);
                r_wcnt <= r_wcnt + 9'd1;
                if (wlast) begin
                    // r_wcnt counts the beats before this one.
                    r_bid <= r_awid;
                    if (r_wdecerr)
                        r_bresp <= RESP_DECERR;
                    else if (r_wcnt != {1'b0, r_awlen})
                        r_bresp <= RESP_SLVERR;
                    else
                        r_bresp <= RESP_OKAY;
                end
            end
        end
    end

    assign awready        = r_awready;
    assign wready         = r_wready;
    assign bvalid         = r_bvalid;
    assign bid            = r_bid;
    assign bresp          = r_bresp;
    assign o_dbg_wr_state = r_wr_state;

    axi_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IW         (IW)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_bank_rdata)
    );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: table of directed transactions, randomized
// transactions against a word-array memory model, and hand-written
// sequences for stalls, same-edge read/write, and reset mid-burst.
// Honours AXI_MEM_DECERR_EN when it is defined for the build.
module tb_axi_mem_slave;
    import axi_mem_pkg::*;

    localparam int MW = 1024;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr;
    logic [7:0]   arlen, awlen;
    logic         arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         arready, rlast, rvalid, awready, wready, bvalid;
    logic [3:0]   rid, bid;
    logic [127:0] rdata;
    logic [1:0]   rresp, bresp;
    rd_state_t    dbg_rd;
    wr_state_t    dbg_wr;

    axi_mem_slave dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .o_dbg_rd_state(dbg_rd), .o_dbg_wr_state(dbg_wr)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference memory: one entry per RAM word.
    logic [127:0] ref_mem [MW];

    typedef struct {
        bit           wr;
        logic [3:0]   id;
        logic [31:0]  addr;
        logic [7:0]   len;
        int           nb;
        logic [15:0]  strb;
        bit           rstrb;
        logic [127:0] pat;
        bit           rnd;
        int           rmode;
        int           bdly;
        logic [1:0]   exp_resp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a, input int beat);
        return int'(((a >> 4) + beat) % MW);
    endfunction

    function automatic bit is_err(input logic [31:0] a);
`ifdef AXI_MEM_DECERR_EN
        return a >= 32'(MW * 16);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           output bit ok);
        bit hs = 0;
        int n = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        while (!hs && n < 50) begin
            hs = arready;
            step();
            n++;
        end
        arvalid = 1'b0;
        ok = hs;
        if (!hs) chk("ar_timeout", 0, 1);
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           output bit ok);
        bit hs = 0;
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        while (!hs && n < 50) begin
            hs = awready;
            step();
            n++;
        end
        awvalid = 1'b0;
        ok = hs;
        if (!hs) chk("aw_timeout", 0, 1);
    endtask

    // Full write transaction; nb beats are sent regardless of len.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int nb, input logic [15:0] strb, input bit rstrb,
                            input logic [127:0] pat, input bit rnd, input logic [1:0] exp_resp,
                            input int bdly);
        bit ok, hs, err;
        int n;
        logic [127:0] d;
        logic [15:0] s;
        err = is_err(addr);
        aw_send(id, addr, len, ok);
        if (!ok) return;
        for (int b = 0; b < nb; b++) begin
            d = rnd ? rnd128() : pat;
            s = rstrb ? 16'($urandom_range(0, 65535)) : strb;
            wvalid = 1'b0;
            if ($urandom_range(0, 3) == 0) step();
            wdata = d; wstrb = s; wlast = (b == nb - 1); wvalid = 1'b1;
            hs = 0; n = 0;
            while (!hs && n < 50) begin
                hs = wready;
                step();
                n++;
            end
            if (!hs) begin
                chk("w_timeout", 0, 1);
                wvalid = 1'b0;
                return;
            end
            if (!err) begin
                for (int i = 0; i < 16; i++)
                    if (s[i]) ref_mem[widx(addr, b)][i*8 +: 8] = d[i*8 +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_lat", bvalid, 1);
        n = 0;
        while (!bvalid && n < 50) begin
            step();
            n++;
        end
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
        for (int k = 0; k < bdly; k++) begin
            chk("b_hold", bvalid, 1);
            chk("aw_block", awready, 0);
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("b_clear", bvalid, 0);
        chk("aw_reopen", awready, 1);
    endtask

    // Full read transaction; rmode 0 = always ready, 1 = toggling, 2 = random.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int rmode);
        bit ok, rr, err;
        int beat = 0;
        int cyc = 0;
        logic [127:0] exp;
        err = is_err(addr);
        ar_send(id, addr, len, ok);
        if (!ok) return;
        chk("r_lat", rvalid, 1);
        while (beat <= int'(len) && cyc < 2000) begin
            rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
            rready = rr;
            chk("r_valid", rvalid, 1);
            if (rvalid) begin
                exp = err ? 128'd0 : ref_mem[widx(addr, beat)];
                chk("rdata", rdata, exp);
                chk("rresp", rresp, err ? 2'b11 : 2'b00);
                chk("rlast", rlast, beat == int'(len));
                chk("rid", rid, id);
                if (rr) beat++;
            end
            step();
            cyc++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) chk("r_timeout", 0, 1);
        chk("r_end", rvalid, 0);
        chk("ar_reopen", arready, 1);
    endtask

    initial begin
        bit ok;
        logic [127:0] old_w, new_w;
        int len, nb;
        logic [31:0] a;

        reset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) step();

        // Reset values.
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rd_state", dbg_rd, R_IDLE);
        chk("rst_wr_state", dbg_wr, W_IDLE);
        reset = 1'b0;
        step();
        chk("post_rst_arready", arready, 1);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 0);

        // Give every word a known value with four 256-beat bursts.
        for (int k = 0; k < 4; k++)
            do_write(4'd0, 32'(k * 4096), 8'd255, 256, 16'hFFFF, 0, '0, 1, 2'b00, 0);

        // Directed table.
        tbl[0]  = '{1, 4'd1, 32'h100,  8'd0, 1, 16'hFFFF, 0, {16{8'hA5}}, 0, 0, 0, 2'b00};
        tbl[1]  = '{0, 4'd1, 32'h100,  8'd0, 0, 16'h0000, 0, '0,          0, 0, 0, 2'b00};
        tbl[2]  = '{1, 4'd2, 32'h100,  8'd0, 1, 16'hFFFF, 0, {16{8'hFF}}, 0, 0, 0, 2'b00};
        tbl[3]  = '{1, 4'd3, 32'h100,  8'd0, 1, 16'h000F, 0, '0,          0, 0, 0, 2'b00};
        tbl[4]  = '{0, 4'd3, 32'h100,  8'd0, 0, 16'h0000, 0, '0,          0, 0, 0, 2'b00};
        tbl[5]  = '{1, 4'd4, 32'h200,  8'd3, 4, 16'hFFFF, 0, '0,          1, 0, 0, 2'b00};
        tbl[6]  = '{0, 4'd4, 32'h200,  8'd3, 0, 16'h0000, 0, '0,          0, 1, 0, 2'b00};
        tbl[7]  = '{1, 4'd5, 32'h300,  8'd1, 1, 16'hFFFF, 0, '0,          1, 0, 5, 2'b10};
        tbl[8]  = '{1, 4'd6, 32'h3FE0, 8'd3, 4, 16'h0000, 1, '0,          1, 0, 0, 2'b00};
        tbl[9]  = '{0, 4'd6, 32'h3FE0, 8'd3, 0, 16'h0000, 0, '0,          0, 2, 0, 2'b00};
        tbl[10] = '{1, 4'd7, 32'h500,  8'd3, 5, 16'hFFFF, 0, '0,          1, 0, 0, 2'b10};
        tbl[11] = '{0, 4'd7, 32'h500,  8'd4, 0, 16'h0000, 0, '0,          0, 2, 0, 2'b00};
        tbl[12] = '{1, 4'd8, 32'h60C,  8'd0, 1, 16'h8001, 0, '0,          1, 0, 2, 2'b00};
        tbl[13] = '{0, 4'd8, 32'h600,  8'd0, 0, 16'h0000, 0, '0,          0, 0, 0, 2'b00};
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr)
                do_write(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].nb, tbl[i].strb, tbl[i].rstrb,
                         tbl[i].pat, tbl[i].rnd, tbl[i].exp_resp, tbl[i].bdly);
            else
                do_read(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].rmode);
        end
        // Partial-strobe readback against literal bytes.
        chk("strb_bytes", ref_mem[16'h10], {{12{8'hFF}}, 32'h0});

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            a   = 32'($urandom_range(0, MW - 1) * 16 + $urandom_range(0, 15));
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 17) : len + 1;
                do_write(4'($urandom), a, 8'(len), nb, 16'hFFFF, 1, '0, 1,
                         (nb != len + 1) ? 2'b10 : 2'b00, $urandom_range(0, 3));
            end else begin
                do_read(4'($urandom), a, 8'(len), $urandom_range(0, 2));
            end
        end

        // AW and W presented together, plus a read of the same word on the W edge.
        old_w = ref_mem[16'h70];
        new_w = rnd128();
        awid = 4'd9; awaddr = 32'h700; awlen = 8'd0; awvalid = 1'b1;
        wdata = new_w; wstrb = 16'hFFFF; wlast = 1'b1; wvalid = 1'b1;
        chk("w_waits_aw", wready, 0);
        chk("aw_open", awready, 1);
        step();
        awvalid = 1'b0;
        chk("w_open", wready, 1);
        arid = 4'd9; araddr = 32'h700; arlen = 8'd0; arvalid = 1'b1;
        chk("ar_open", arready, 1);
        step();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        ref_mem[16'h70] = new_w;
        chk("rw_rvalid", rvalid, 1);
        chk("rw_same_word", rdata, old_w);
        chk("rw_bvalid", bvalid, 1);
        chk("rw_bresp", bresp, 2'b00);
        rready = 1'b1; bready = 1'b1;
        step();
        rready = 1'b0; bready = 1'b0;
        do_read(4'd9, 32'h700, 8'd0, 0);

        // Reset during beat 2 of an 8-beat read.
        ar_send(4'd10, 32'h200, 8'd7, ok);
        if (ok) begin
            rready = 1'b1;
            step();
            step();
            chk("rst_mid_beat2", rdata, ref_mem[widx(32'h200, 2)]);
            reset = 1'b1; rready = 1'b0;
            step();
            chk("rst_mid_rvalid", rvalid, 0);
            chk("rst_mid_arready", arready, 0);
            reset = 1'b0;
            step();
            chk("rst_mid_rvalid2", rvalid, 0);
            chk("rst_mid_arready2", arready, 1);
        end
        do_read(4'd10, 32'h200, 8'd3, 0);
        do_read(4'd11, 32'h100, 8'd0, 0);

`ifdef AXI_MEM_DECERR_EN
        do_read(4'd12, 32'(MW * 16), 8'd1, 0);
        do_write(4'd12, 32'(MW * 16), 8'd0, 1, 16'hFFFF, 0, {16{8'h3C}}, 0, 2'b11, 0);
        do_write(4'd12, 32'(MW * 16), 8'd1, 1, 16'hFFFF, 0, {16{8'h3C}}, 0, 2'b11, 0);
        do_read(4'd12, 32'h0, 8'd0, 0);
`else
        do_write(4'd12, 32'(MW * 16 + 16), 8'd0, 1, 16'hFFFF, 0, {16{8'h3C}}, 0, 2'b00, 0);
        chk("alias_model", ref_mem[1], {16{8'h3C}});
        do_read(4'd12, 32'h10, 8'd0, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "time limit");
    end

endmodule
